// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t : sequencer states (idle, shifting bits, result presented)
//   cnt_w() : bit-counter width for a given operand width, never below 1
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A 1-bit operand still needs a 1-bit counter, so $clog2(1)=0 is lifted to 1.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// 1-bit combinational full-adder cell.
//   a, b  : addend bits
//   c     : carry in
//   sum   : a ^ b ^ c
//   carry : carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer. Captures a, b, cin when start is seen
// in IDLE, then feeds one full-adder cell LSB-first, one bit per clock, with
// the carry held in a flop. The result {cout, sum} = a + b + cin is written
// on the last bit edge and accompanied by a one-cycle done pulse.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : request, only honoured in IDLE
//   a, b  : WIDTH-bit operands, captured on the accepting edge
//   cin   : carry-in, captured on the accepting edge
//   busy  : high while not IDLE
//   done  : one-cycle pulse, sum/cout valid
//   sum   : WIDTH-bit result register
//   cout  : carry-out register
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    import serial_arith_pkg::*;

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             accept;
    logic             last;

    assign accept = (state == ST_IDLE) && start;
    assign last   = (state == ST_RUN) && (cnt == CNT_LAST);

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    // Written as shift/OR so the expression also holds for WIDTH=1.
    assign acc_nxt = (acc >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    full_adder u_fa (
        .a     (sh_a[0]),
        .b     (sh_b[0]),
        .c     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (start) state <= ST_RUN;
                ST_RUN:  if (cnt == CNT_LAST) state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand shifters, carry flop, sum accumulator, bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            carry <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            carry <= fa_carry;
            acc   <= acc_nxt;
            cnt   <= cnt + 1'b1;
        end
    end

    // Registered outputs; sum/cout only change on the last bit edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            busy <= accept || (state == ST_RUN);
            done <= last;
            if (last) begin
                sum  <= acc_nxt;
                cout <= fa_carry;
            end
        end
    end

endmodule
